// File: rtl/mem_arbiter.sv
// Two-way memory port arbiter between the I-cache and D-cache miss paths.
// Build option MEM_ARB_RR_EN selects round-robin tie-breaking instead of dc-first.
module mem_arbiter #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int BEATS     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ic_req_valid,
    output logic                   ic_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_req_addr,
    input  logic                   ic_req_rw,
    input  logic                   ic_req_data_valid,
    output logic                   ic_req_data_ready,
    input  logic [DATA_BITS-1:0]   ic_req_data_bits,
    input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
    output logic                   ic_resp_valid,
    output logic [DATA_BITS-1:0]   ic_resp_data,
    input  logic                   dc_req_valid,
    output logic                   dc_req_ready,
    input  logic [ADDR_BITS-1:0]   dc_req_addr,
    input  logic                   dc_req_rw,
    input  logic                   dc_req_data_valid,
    output logic                   dc_req_data_ready,
    input  logic [DATA_BITS-1:0]   dc_req_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
    output logic                   dc_resp_valid,
    output logic [DATA_BITS-1:0]   dc_resp_data,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_rw,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data
);

    localparam int CNT_BITS = $clog2(BEATS + 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(BEATS);
    localparam logic IC = 1'b0;
    localparam logic DC = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                pend_q, pend_d;
    logic                last_q, last_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    logic                arb_sel;
    logic                sel;
    logic                sel_valid;
    logic                sel_rw;
    logic                sel_dvalid;
    logic                fwd_req;
    logic                fwd_data;
    logic                req_rdy;
    logic                data_rdy;
    logic                addr_hs;
    logic                data_hs;
    logic [CNT_BITS-1:0] cnt_inc;

    // Fresh arbitration choice; parks on the last grant when nobody asks.
    always_comb begin
        arb_sel = last_q;
`ifdef MEM_ARB_RR_EN
        if (ic_req_valid && dc_req_valid) begin
            arb_sel = ~last_q;
        end else if (dc_req_valid) begin
            arb_sel = DC;
        end else if (ic_req_valid) begin
            arb_sel = IC;
        end
`else
        if (dc_req_valid) begin
            arb_sel = DC;
        end else if (ic_req_valid) begin
            arb_sel = IC;
        end
`endif
    end

    // Selected requester: frozen while stalled, locked to owner otherwise.
    always_comb begin
        sel = owner_q;
        if (state_q == S_IDLE && !pend_q) begin
            sel = arb_sel;
        end
        sel_valid  = sel ? dc_req_valid : ic_req_valid;
        sel_rw     = sel ? dc_req_rw : ic_req_rw;
        sel_dvalid = sel ? dc_req_data_valid : ic_req_data_valid;
    end

    // Channel gating per state; data in IDLE only rides the address beat.
    always_comb begin
        fwd_req  = 1'b0;
        fwd_data = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                fwd_req  = 1'b1;
                fwd_data = sel_valid & sel_rw & mem_req_ready;
            end
            S_WRITE: begin
                fwd_req  = 1'b1;
                fwd_data = 1'b1;
            end
            default: begin
                fwd_req  = 1'b0;
                fwd_data = 1'b0;
            end
        endcase
    end

    assign mem_req_valid      = fwd_req & sel_valid;
    assign mem_req_data_valid = fwd_data & sel_dvalid;
    assign mem_req_addr       = sel ? dc_req_addr : ic_req_addr;
    assign mem_req_rw         = sel_rw;
    assign mem_req_data_bits  = sel ? dc_req_data_bits : ic_req_data_bits;
    assign mem_req_data_mask  = !mem_req_data_valid ? '0 :
                                (sel ? dc_req_data_mask : ic_req_data_mask);

    assign req_rdy           = mem_req_valid & mem_req_ready;
    assign data_rdy          = fwd_data & mem_req_data_ready;
    assign ic_req_ready      = (sel == IC) & req_rdy;
    assign dc_req_ready      = (sel == DC) & req_rdy;
    assign ic_req_data_ready = (sel == IC) & data_rdy;
    assign dc_req_data_ready = (sel == DC) & data_rdy;

    assign ic_resp_valid = (state_q == S_READ) & (owner_q == IC) & mem_resp_valid;
    assign dc_resp_valid = (state_q == S_READ) & (owner_q == DC) & mem_resp_valid;
    assign ic_resp_data  = mem_resp_data;
    assign dc_resp_data  = mem_resp_data;

    assign addr_hs = mem_req_valid & mem_req_ready;
    assign data_hs = mem_req_data_valid & mem_req_data_ready;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_BITS'(1);

    // Next-state: grant, beat counting and completion.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        pend_d  = pend_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (addr_hs) begin
                    owner_d = sel;
                    pend_d  = 1'b0;
                    if (!sel_rw) begin
                        state_d = S_READ;
                        cnt_d   = '0;
                    end else if (data_hs && cnt_inc == CNT_MAX) begin
                        cnt_d  = '0;
                        last_d = sel;
                    end else begin
                        state_d = S_WRITE;
                        cnt_d   = data_hs ? cnt_inc : '0;
                    end
                end else if (mem_req_valid) begin
                    pend_d  = 1'b1;
                    owner_d = sel;
                end else begin
                    pend_d = 1'b0;
                end
            end
            S_WRITE: begin
                if (data_hs) begin
                    if (cnt_inc == CNT_MAX) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        last_d  = owner_q;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_READ: begin
                if (mem_resp_valid) begin
                    if (cnt_inc == CNT_MAX) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        last_d  = owner_q;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= DC;
            pend_q  <= 1'b0;
            last_q  <= IC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level model of grant and routing.
module tb_mem_arbiter;

    localparam int AB = 28;
    localparam int DB = 128;
    localparam int MB = 16;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req_valid, ic_req_ready, ic_req_rw;
    logic [AB-1:0] ic_req_addr;
    logic          ic_req_data_valid, ic_req_data_ready;
    logic [DB-1:0] ic_req_data_bits;
    logic [MB-1:0] ic_req_data_mask;
    logic          ic_resp_valid;
    logic [DB-1:0] ic_resp_data;
    logic          dc_req_valid, dc_req_ready, dc_req_rw;
    logic [AB-1:0] dc_req_addr;
    logic          dc_req_data_valid, dc_req_data_ready;
    logic [DB-1:0] dc_req_data_bits;
    logic [MB-1:0] dc_req_data_mask;
    logic          dc_resp_valid;
    logic [DB-1:0] dc_resp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AB-1:0] mem_req_addr;
    logic          mem_req_data_valid, mem_req_data_ready;
    logic [DB-1:0] mem_req_data_bits;
    logic [MB-1:0] mem_req_data_mask;
    logic          mem_resp_valid;
    logic [DB-1:0] mem_resp_data;

    int errs = 0;
    int checks = 0;
    bit m_last = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
        .ic_req_addr(ic_req_addr), .ic_req_rw(ic_req_rw),
        .ic_req_data_valid(ic_req_data_valid), .ic_req_data_ready(ic_req_data_ready),
        .ic_req_data_bits(ic_req_data_bits), .ic_req_data_mask(ic_req_data_mask),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_addr(dc_req_addr), .dc_req_rw(dc_req_rw),
        .dc_req_data_valid(dc_req_data_valid), .dc_req_data_ready(dc_req_data_ready),
        .dc_req_data_bits(dc_req_data_bits), .dc_req_data_mask(dc_req_data_mask),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ic_req_valid = 0; ic_req_addr = '0; ic_req_rw = 0;
        ic_req_data_valid = 0; ic_req_data_bits = '0; ic_req_data_mask = '0;
        dc_req_valid = 0; dc_req_addr = '0; dc_req_rw = 0;
        dc_req_data_valid = 0; dc_req_data_bits = '0; dc_req_data_mask = '0;
        mem_req_ready = 0; mem_req_data_ready = 0;
        mem_resp_valid = 0; mem_resp_data = '0;
    endtask

    // Model of the grant rule: 1 = dc, 0 = ic.
    function automatic bit pick(bit icv, bit dcv);
        if (icv && dcv) begin
`ifdef MEM_ARB_RR_EN
            return ~m_last;
`else
            return 1'b1;
`endif
        end
        return dcv;
    endfunction

    function automatic logic [DB-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        logic [8:0] v;
        clear_in();
        reset = 1;
        mem_req_ready = 1; mem_req_data_ready = 1; mem_resp_valid = 1;
        tick(); tick();
        v = {mem_req_valid, mem_req_data_valid, ic_req_ready, dc_req_ready,
             ic_req_data_ready, dc_req_data_ready, ic_resp_valid, dc_resp_valid,
             |mem_req_data_mask};
        checks++;
        if (v !== 9'b0) begin
            errs++; $display("FAIL reset_outs: got %b want 000000000", v);
        end
        reset = 0;
        tick();
        v = {mem_req_valid, mem_req_data_valid, ic_req_ready, dc_req_ready,
             ic_req_data_ready, dc_req_data_ready, ic_resp_valid, dc_resp_valid,
             |mem_req_data_mask};
        checks++;
        if (v !== 9'b0) begin
            errs++; $display("FAIL post_reset_outs: got %b want 000000000", v);
        end
        clear_in();
        m_last = 1'b0;
        tick();
    endtask

    task automatic test_ic_read();
        clear_in();
        ic_req_valid = 1; ic_req_addr = 28'h10; mem_req_ready = 1;
        #1;
        checks++;
        if ({mem_req_valid, ic_req_ready, dc_req_ready} !== 3'b110 || mem_req_addr !== 28'h10) begin
            errs++;
            $display("FAIL t1_grant: v/icr/dcr=%b addr=%h want 110 addr=10",
                     {mem_req_valid, ic_req_ready, dc_req_ready}, mem_req_addr);
        end
        tick();
        ic_req_valid = 0;
        for (int b = 0; b < NB; b++) begin
            mem_resp_valid = 1; mem_resp_data = DB'(8'hA0 + b);
            #1;
            checks++;
            if ({ic_resp_valid, dc_resp_valid} !== 2'b10 || ic_resp_data !== DB'(8'hA0 + b)) begin
                errs++;
                $display("FAIL t1_beat%0d: ic/dc=%b data=%h want 10 data=%h",
                         b, {ic_resp_valid, dc_resp_valid}, ic_resp_data, 8'hA0 + b);
            end
            tick();
        end
        m_last = 1'b0;
        mem_resp_valid = 0; mem_req_ready = 0;
        ic_req_valid = 1; ic_req_addr = 28'h11;
        #1;
        checks++;
        if ({mem_req_valid, ic_req_ready, ic_resp_valid} !== 3'b100) begin
            errs++;
            $display("FAIL t1_idle: v/icr/icresp=%b want 100",
                     {mem_req_valid, ic_req_ready, ic_resp_valid});
        end
        clear_in();
        tick();
    endtask

    task automatic test_priority();
        bit w;
        for (int k = 0; k < 2; k++) begin
            clear_in();
            ic_req_valid = 1; ic_req_addr = 28'h20;
            dc_req_valid = 1; dc_req_addr = 28'h30;
            mem_req_ready = 1;
            w = pick(1'b1, 1'b1);
            #1;
            checks++;
            if ({ic_req_ready, dc_req_ready} !== {~w, w} ||
                mem_req_addr !== (w ? 28'h30 : 28'h20)) begin
                errs++;
                $display("FAIL prio%0d: icr/dcr=%b addr=%h want %b", k,
                         {ic_req_ready, dc_req_ready}, mem_req_addr, {~w, w});
            end
            tick();
            clear_in();
            for (int b = 0; b < NB; b++) begin
                mem_resp_valid = 1; mem_resp_data = DB'(b);
                #1;
                checks++;
                if ({ic_resp_valid, dc_resp_valid} !== {~w, w}) begin
                    errs++;
                    $display("FAIL prio%0d_beat%0d: ic/dc=%b want %b", k, b,
                             {ic_resp_valid, dc_resp_valid}, {~w, w});
                end
                tick();
            end
            m_last = w;
            mem_resp_valid = 0;
        end
    endtask

    task automatic test_dc_write();
        logic [5:0] pat;
        int nb;
        pat = 6'b110101;
        nb = 0;
        clear_in();
        dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h40;
        dc_req_data_valid = 1; dc_req_data_mask = '1; mem_req_ready = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                dc_req_valid = 0;
                ic_req_valid = 1; ic_req_addr = 28'h50; ic_req_rw = 0;
            end
            mem_req_data_ready = pat[i];
            dc_req_data_bits = DB'(32'hD0 + nb);
            #1;
            checks++;
            if (mem_req_data_valid !== 1'b1 || mem_req_data_mask !== 16'hFFFF ||
                mem_req_data_bits !== DB'(32'hD0 + nb) || ic_req_ready !== 1'b0 ||
                ic_req_data_ready !== 1'b0 || dc_req_data_ready !== pat[i]) begin
                errs++;
                $display("FAIL wr_cyc%0d: dv=%b mask=%h bits=%h icr=%b dcdr=%b want 1 ffff %h 0 %b",
                         i, mem_req_data_valid, mem_req_data_mask, mem_req_data_bits,
                         ic_req_ready, dc_req_data_ready, 32'hD0 + nb, pat[i]);
            end
            if (mem_req_data_valid && mem_req_data_ready) nb++;
            tick();
        end
        checks++;
        if (nb !== 4) begin
            errs++; $display("FAIL wr_beats: got %0d want 4", nb);
        end
        m_last = 1'b1;
        #1;
        checks++;
        if ({ic_req_ready, mem_req_data_valid, dc_req_data_ready} !== 3'b100 ||
            mem_req_addr !== 28'h50 || mem_req_data_mask !== '0) begin
            errs++;
            $display("FAIL wr_next_grant: icr/dv/dcdr=%b addr=%h mask=%h want 100 50 0",
                     {ic_req_ready, mem_req_data_valid, dc_req_data_ready},
                     mem_req_addr, mem_req_data_mask);
        end
        tick();
        clear_in();
        for (int b = 0; b < NB; b++) begin
            mem_resp_valid = 1;
            #1;
            checks++;
            if ({ic_resp_valid, dc_resp_valid} !== 2'b10) begin
                errs++;
                $display("FAIL wr_ic_beat%0d: ic/dc=%b want 10", b, {ic_resp_valid, dc_resp_valid});
            end
            tick();
        end
        m_last = 1'b0;
        mem_resp_valid = 0;
    endtask

    task automatic test_pend();
        clear_in();
        ic_req_valid = 1; ic_req_addr = 28'h60;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin
                dc_req_valid = 1; dc_req_addr = 28'h70;
            end
            mem_req_ready = (c == 4);
            #1;
            checks++;
            if ({mem_req_valid, ic_req_ready, dc_req_ready} !== {1'b1, c == 4, 1'b0} ||
                mem_req_addr !== 28'h60) begin
                errs++;
                $display("FAIL pend_cyc%0d: v/icr/dcr=%b addr=%h want 1%b0 addr=60", c,
                         {mem_req_valid, ic_req_ready, dc_req_ready}, mem_req_addr, c == 4);
            end
            tick();
        end
        ic_req_valid = 0;
        for (int b = 0; b < NB; b++) begin
            mem_resp_valid = 1;
            #1;
            checks++;
            if ({ic_resp_valid, dc_resp_valid, mem_req_valid, dc_req_ready} !== 4'b1000) begin
                errs++;
                $display("FAIL pend_beat%0d: ic/dc/v/dcr=%b want 1000", b,
                         {ic_resp_valid, dc_resp_valid, mem_req_valid, dc_req_ready});
            end
            tick();
        end
        m_last = 1'b0;
        mem_resp_valid = 0; mem_req_ready = 1;
        #1;
        checks++;
        if (dc_req_ready !== 1'b1 || mem_req_addr !== 28'h70) begin
            errs++;
            $display("FAIL pend_dc_grant: dcr=%b addr=%h want 1 70", dc_req_ready, mem_req_addr);
        end
        tick();
        clear_in();
        for (int b = 0; b < NB; b++) begin
            mem_resp_valid = 1;
            tick();
        end
        m_last = 1'b1;
        mem_resp_valid = 0;
    endtask

    task automatic test_reset_mid();
        clear_in();
        ic_req_valid = 1; ic_req_addr = 28'h80; mem_req_ready = 1;
        tick();
        ic_req_valid = 0;
        mem_resp_valid = 1;
        tick(); tick();
        mem_resp_valid = 0;
        reset = 1;
        tick();
        reset = 0;
        m_last = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1;
            #1;
            checks++;
            if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin
                errs++;
                $display("FAIL rst_drop%0d: ic/dc=%b want 00", b, {ic_resp_valid, dc_resp_valid});
            end
            tick();
        end
        mem_resp_valid = 0;
        ic_req_valid = 1; ic_req_addr = 28'h90;
        #1;
        checks++;
        if (ic_req_ready !== 1'b1 || mem_req_addr !== 28'h90) begin
            errs++;
            $display("FAIL rst_regrant: icr=%b addr=%h want 1 90", ic_req_ready, mem_req_addr);
        end
        tick();
        ic_req_valid = 0;
        for (int b = 0; b <= NB; b++) begin
            mem_resp_valid = 1;
            #1;
            checks++;
            if (ic_resp_valid !== (b < NB)) begin
                errs++;
                $display("FAIL rst_count%0d: icresp=%b want %b", b, ic_resp_valid, b < NB);
            end
            tick();
        end
        m_last = 1'b0;
        mem_resp_valid = 0;
    endtask

    task automatic test_stray_resp();
        clear_in();
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1;
            #1;
            checks++;
            if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin
                errs++;
                $display("FAIL stray%0d: ic/dc=%b want 00", b, {ic_resp_valid, dc_resp_valid});
            end
            tick();
        end
        mem_resp_valid = 0;
        dc_req_valid = 1; dc_req_addr = 28'hB0; mem_req_ready = 1;
        tick();
        dc_req_valid = 0;
        for (int b = 0; b <= NB; b++) begin
            mem_resp_valid = 1;
            #1;
            checks++;
            if (dc_resp_valid !== (b < NB) || ic_resp_valid !== 1'b0) begin
                errs++;
                $display("FAIL stray_count%0d: dc/ic=%b%b want %b0", b,
                         dc_resp_valid, ic_resp_valid, b < NB);
            end
            tick();
        end
        m_last = 1'b1;
        mem_resp_valid = 0;
    endtask

    task automatic test_random();
        bit icv, dcv, w, rw, dr, rv, ok;
        int stall, nb, cyc;
        logic [AB-1:0] ia, da;
        logic [DB-1:0] wb, rd;
        logic [MB-1:0] wm;
        for (int t = 0; t < 40; t++) begin
            clear_in();
            icv = 1'($urandom_range(0, 1));
            dcv = 1'($urandom_range(0, 1));
            if (!icv && !dcv) icv = 1;
            ia = AB'($urandom); da = AB'($urandom);
            ic_req_addr = ia; dc_req_addr = da;
            ic_req_rw = 1'($urandom); dc_req_rw = 1'($urandom);
            ic_req_valid = icv; dc_req_valid = dcv;
            ic_req_data_valid = ic_req_rw; dc_req_data_valid = dc_req_rw;
            wm = MB'($urandom); wb = rnd128();
            ic_req_data_mask = wm; dc_req_data_mask = wm;
            ic_req_data_bits = wb; dc_req_data_bits = wb;
            w = pick(icv, dcv);
            rw = w ? dc_req_rw : ic_req_rw;
            stall = $urandom_range(0, 3);
            nb = 0;
            for (int s = 0; s <= stall; s++) begin
                if (s == 1 && $urandom_range(0, 1) == 1) begin
                    ic_req_valid = 1; dc_req_valid = 1;
                end
                mem_req_ready = (s == stall);
                dr = (s == stall) ? 1'($urandom) : 1'b0;
                mem_req_data_ready = dr;
                #1;
                ok = mem_req_valid === 1'b1 && mem_req_addr === (w ? da : ia) &&
                     {ic_req_ready, dc_req_ready} === ((s == stall) ? {~w, w} : 2'b00) &&
                     mem_req_data_valid === (rw && s == stall) &&
                     (!(rw && s == stall) || mem_req_data_mask === wm) &&
                     (rw && s == stall || mem_req_data_mask === '0);
                checks++;
                if (!ok) begin
                    errs++;
                    $display("FAIL rnd%0d_addr s%0d: v=%b addr=%h icr/dcr=%b dv=%b want addr=%h w=%b rw=%b",
                             t, s, mem_req_valid, mem_req_addr, {ic_req_ready, dc_req_ready},
                             mem_req_data_valid, w ? da : ia, w, rw);
                end
                if (rw && dr && s == stall) nb++;
                tick();
            end
            if (w) dc_req_valid = 0; else ic_req_valid = 0;
            cyc = 0;
            while (nb < NB && cyc < 60) begin
                if (rw) begin
                    dr = 1'($urandom); wb = rnd128();
                    mem_req_data_ready = dr;
                    mem_resp_valid = 1'($urandom);
                    if (w) dc_req_data_bits = wb; else ic_req_data_bits = wb;
                    #1;
                    ok = mem_req_data_valid === 1'b1 && mem_req_data_bits === wb &&
                         mem_req_data_mask === wm && mem_req_valid === 1'b0 &&
                         {ic_req_data_ready, dc_req_data_ready} === (dr ? {~w, w} : 2'b00) &&
                         {ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid} === 4'b0;
                    checks++;
                    if (!ok) begin
                        errs++;
                        $display("FAIL rnd%0d_wbeat%0d: dv=%b bits=%h mask=%h v=%b dr=%b%b resp=%b%b",
                                 t, nb, mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
                                 mem_req_valid, ic_req_data_ready, dc_req_data_ready,
                                 ic_resp_valid, dc_resp_valid);
                    end
                    if (dr) nb++;
                end else begin
                    rv = 1'($urandom); rd = rnd128();
                    mem_resp_valid = rv; mem_resp_data = rd;
                    #1;
                    ok = {ic_resp_valid, dc_resp_valid} === (rv ? {~w, w} : 2'b00) &&
                         (w ? dc_resp_data : ic_resp_data) === rd &&
                         {mem_req_valid, ic_req_ready, dc_req_ready} === 3'b0;
                    checks++;
                    if (!ok) begin
                        errs++;
                        $display("FAIL rnd%0d_rbeat%0d: resp=%b%b v=%b want resp=%b%b",
                                 t, nb, ic_resp_valid, dc_resp_valid, mem_req_valid,
                                 rv & ~w, rv & w);
                    end
                    if (rv) nb++;
                end
                tick();
                cyc++;
            end
            checks++;
            if (nb < NB) begin
                errs++;
                $display("FAIL rnd%0d_timeout: beats=%0d want %0d", t, nb, NB);
            end
            m_last = w;
            mem_resp_valid = 0; mem_req_data_ready = 0;
        end
        clear_in();
        tick();
    endtask

    initial begin
        reset = 1;
        clear_in();
        test_reset();
        test_ic_read();
        test_priority();
        test_dc_write();
        test_pend();
        test_reset_mid();
        test_stray_resp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
